// File: rtl/crc_engine.sv
// Parametrised CRC generator/checker: DATA_W bits per accepted beat, frames closed by din_last,
// result held under a valid/ready handshake together with a residue-match flag.
module crc_engine #(
   parameter int unsigned CRC_W   = 8,
   parameter logic [31:0] POLY    = 32'h0000_0007,
   parameter logic [31:0] INIT    = 32'h0000_0000,
   parameter logic [31:0] XOROUT  = 32'h0000_0000,
   parameter bit          REFIN   = 1'b0,
   parameter bit          REFOUT  = 1'b0,
   parameter int unsigned DATA_W  = 8,
   parameter logic [31:0] RESIDUE = 32'h0000_0000,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [DATA_W-1:0] din,
   input  logic              din_vld,
   input  logic              din_last,
   output logic              din_rdy,
   output logic [CRC_W-1:0]  crc_out,
   output logic              crc_ok,
   output logic [CNT_W-1:0]  crc_beats,
   output logic              crc_vld,
   input  logic              crc_rdy
);

   localparam logic [CRC_W-1:0] POLY_C    = POLY[CRC_W-1:0];
   localparam logic [CRC_W-1:0] INIT_C    = INIT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] XOROUT_C  = XOROUT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] RESIDUE_C = RESIDUE[CRC_W-1:0];

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_OUTPUT} state_t;

   state_t             state_q;
   logic [CRC_W-1:0]   crc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               din_rdy_q;
   logic               crc_vld_q;
   logic [CRC_W-1:0]   crc_out_q;
   logic               crc_ok_q;
   logic [CNT_W-1:0]   crc_beats_q;

   logic               accept;
   logic [CRC_W-1:0]   crc_d;
   logic [CNT_W-1:0]   cnt_d;

   // Direct (non-augmented) update, one bit per iteration, unrolled across the beat.
   function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] crc_in,
                                                   input logic [DATA_W-1:0] data);
      logic [CRC_W-1:0] c;
      logic             b;
      c = crc_in;
      for (int i = 0; i < DATA_W; i++) begin
         b = REFIN ? data[i] : data[DATA_W-1-i];
         c = (c << 1) ^ ((c[CRC_W-1] ^ b) ? POLY_C : '0);
      end
      return c;
   endfunction

   function automatic logic [CRC_W-1:0] reflect(input logic [CRC_W-1:0] v);
      logic [CRC_W-1:0] r;
      for (int i = 0; i < CRC_W; i++) begin
         r[i] = v[CRC_W-1-i];
      end
      return r;
   endfunction

   function automatic logic [CRC_W-1:0] crc_final(input logic [CRC_W-1:0] raw);
      return (REFOUT ? reflect(raw) : raw) ^ XOROUT_C;
   endfunction

   // A frame's first beat always starts from INIT, so no state carries between frames.
   always_comb begin
      accept = din_vld && din_rdy_q;
      crc_d  = crc_update((state_q == S_IDLE) ? INIT_C : crc_q, din);
      cnt_d  = cnt_q;
      if (state_q == S_IDLE) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q     <= S_IDLE;
         crc_q       <= INIT_C;
         cnt_q       <= '0;
         din_rdy_q   <= !rst;
         crc_vld_q   <= 1'b0;
         crc_out_q   <= '0;
         crc_ok_q    <= 1'b0;
         crc_beats_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_BUSY: begin
               din_rdy_q <= 1'b1;
               if (accept) begin
                  crc_q <= crc_d;
                  cnt_q <= cnt_d;
                  if (din_last) begin
                     state_q     <= S_OUTPUT;
                     din_rdy_q   <= 1'b0;
                     crc_vld_q   <= 1'b1;
                     crc_out_q   <= crc_final(crc_d);
                     crc_ok_q    <= (crc_d == RESIDUE_C);
                     crc_beats_q <= cnt_d;
                  end else begin
                     state_q <= S_BUSY;
                  end
               end
            end
            S_OUTPUT: begin
               if (crc_rdy) begin
                  state_q     <= S_IDLE;
                  crc_q       <= INIT_C;
                  cnt_q       <= '0;
                  din_rdy_q   <= 1'b1;
                  crc_vld_q   <= 1'b0;
                  crc_out_q   <= '0;
                  crc_ok_q    <= 1'b0;
                  crc_beats_q <= '0;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               din_rdy_q <= 1'b1;
            end
         endcase
      end
   end

   assign din_rdy   = din_rdy_q;
   assign crc_vld   = crc_vld_q;
   assign crc_out   = crc_out_q;
   assign crc_ok    = crc_ok_q;
   assign crc_beats = crc_beats_q;

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: CRC-8, CRC-16/CCITT-FALSE (byte and serial), CRC-32 and a
// narrow-counter instance, sharing one byte stream; plus handshake, abort and reset sequences.
module tb_crc_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, clr;
   logic [7:0] din;
   logic       din_vld, din_last, crc_rdy;

   logic        a_rdy, a_ok, a_vld;  logic [7:0]  a_out; logic [15:0] a_beats;
   logic        b_rdy, b_ok, b_vld;  logic [15:0] b_out; logic [15:0] b_beats;
   logic        d_rdy, d_ok, d_vld;  logic [31:0] d_out; logic [15:0] d_beats;
   logic        e_rdy, e_ok, e_vld;  logic [7:0]  e_out; logic [1:0]  e_beats;

   logic [0:0]  s_din;
   logic        s_vld_i, s_last, s_crc_rdy;
   logic        s_rdy, s_ok, s_vld;  logic [15:0] s_out; logic [15:0] s_beats;

   int n_tests = 0;
   int n_fail  = 0;

   crc_engine u_a (.clk(clk), .rst(rst), .clr(clr), .din(din), .din_vld(din_vld),
      .din_last(din_last), .din_rdy(a_rdy), .crc_out(a_out), .crc_ok(a_ok),
      .crc_beats(a_beats), .crc_vld(a_vld), .crc_rdy(crc_rdy));

   crc_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF)) u_b (.clk(clk), .rst(rst),
      .clr(clr), .din(din), .din_vld(din_vld), .din_last(din_last), .din_rdy(b_rdy),
      .crc_out(b_out), .crc_ok(b_ok), .crc_beats(b_beats), .crc_vld(b_vld), .crc_rdy(crc_rdy));

   crc_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
      .REFIN(1'b1), .REFOUT(1'b1)) u_d (.clk(clk), .rst(rst), .clr(clr), .din(din),
      .din_vld(din_vld), .din_last(din_last), .din_rdy(d_rdy), .crc_out(d_out), .crc_ok(d_ok),
      .crc_beats(d_beats), .crc_vld(d_vld), .crc_rdy(crc_rdy));

   crc_engine #(.CNT_W(2)) u_e (.clk(clk), .rst(rst), .clr(clr), .din(din), .din_vld(din_vld),
      .din_last(din_last), .din_rdy(e_rdy), .crc_out(e_out), .crc_ok(e_ok),
      .crc_beats(e_beats), .crc_vld(e_vld), .crc_rdy(crc_rdy));

   crc_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .DATA_W(1)) u_s (.clk(clk),
      .rst(rst), .clr(clr), .din(s_din), .din_vld(s_vld_i), .din_last(s_last), .din_rdy(s_rdy),
      .crc_out(s_out), .crc_ok(s_ok), .crc_beats(s_beats), .crc_vld(s_vld), .crc_rdy(s_crc_rdy));

   typedef struct {
      logic [95:0] msg;   // right-justified, first byte most significant
      int          len;
      logic [7:0]  e8;
      logic        ok8;
      logic [15:0] e16;
      bit          c16;
      logic [31:0] e32;
      bit          c32;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_rdy();
      int t = 0;
      while (!a_rdy && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("din_rdy_wait", 64'(a_rdy), 64'h1);
   endtask

   task automatic send_beats(input logic [95:0] msg, input int n, input logic last);
      for (int k = 0; k < n; k++) begin
         din      = msg[8*(n-1-k) +: 8];
         din_vld  = 1'b1;
         din_last = last && (k == n-1);
         @(posedge clk); #1;
      end
      din_vld  = 1'b0;
      din_last = 1'b0;
      din      = 8'h00;
   endtask

   task automatic check_vec(input vec_t v);
      int eb;
      eb = (v.len > 3) ? 3 : v.len;
      chk("a_vld_latency", 64'(a_vld), 64'h1);
      chk("a_out",   64'(a_out),   64'(v.e8));
      chk("a_ok",    64'(a_ok),    64'(v.ok8));
      chk("a_beats", 64'(a_beats), 64'(v.len));
      chk("e_vld",   64'(e_vld),   64'h1);
      chk("e_out",   64'(e_out),   64'(v.e8));
      chk("e_ok",    64'(e_ok),    64'(v.ok8));
      chk("e_beats_sat", 64'(e_beats), 64'(eb));
      if (v.c16) begin
         chk("b_vld",   64'(b_vld),   64'h1);
         chk("b_out",   64'(b_out),   64'(v.e16));
         chk("b_ok",    64'(b_ok),    64'h0);
         chk("b_beats", 64'(b_beats), 64'(v.len));
      end
      if (v.c32) begin
         chk("d_vld",   64'(d_vld),   64'h1);
         chk("d_out",   64'(d_out),   64'(v.e32));
         chk("d_ok",    64'(d_ok),    64'h0);
         chk("d_beats", 64'(d_beats), 64'(v.len));
      end
   endtask

   task automatic release_result();
      crc_rdy = 1'b1;
      @(posedge clk); #1;
      crc_rdy = 1'b0;
      chk("rel_a_vld",   64'(a_vld),   64'h0);
      chk("rel_a_out",   64'(a_out),   64'h0);
      chk("rel_a_beats", 64'(a_beats), 64'h0);
      chk("rel_a_rdy",   64'(a_rdy),   64'h1);
      chk("rel_b_rdy",   64'(b_rdy),   64'h1);
      chk("rel_d_rdy",   64'(d_rdy),   64'h1);
      chk("rel_e_rdy",   64'(e_rdy),   64'h1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [71:0] sm;
      sm = "123456789";

      vecs[0] = '{{24'h0, "123456789"},         9, 8'hF4, 1'b0, 16'h29B1, 1'b1, 32'hCBF43926, 1'b1};
      vecs[1] = '{{88'h0, 8'h01},               1, 8'h07, 1'b0, 16'hF1D1, 1'b1, 32'h0, 1'b0};
      vecs[2] = '{{16'h0, "123456789", 8'hF4}, 10, 8'h00, 1'b1, 16'h0, 1'b0, 32'h0, 1'b0};
      vecs[3] = '{{16'h0, "123456788", 8'hF4}, 10, 8'h15, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0};
      vecs[4] = '{{80'h0, 16'h0100},            2, 8'h15, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0};
      vecs[5] = '{{88'h0, 8'h00},               1, 8'h00, 1'b1, 16'h0, 1'b0, 32'h0, 1'b0};

      rst = 1'b1; clr = 1'b0; din = 8'h00; din_vld = 1'b0; din_last = 1'b0; crc_rdy = 1'b0;
      s_din = 1'b0; s_vld_i = 1'b0; s_last = 1'b0; s_crc_rdy = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_din_rdy",   64'(a_rdy),   64'h0);
      chk("rst_crc_vld",   64'(a_vld),   64'h0);
      chk("rst_crc_out",   64'(a_out),   64'h0);
      chk("rst_crc_ok",    64'(a_ok),    64'h0);
      chk("rst_crc_beats", 64'(a_beats), 64'h0);
      rst = 1'b0;
      chk("rdy_low_at_release", 64'(a_rdy), 64'h0);
      @(posedge clk); #1;
      chk("rdy_after_release", 64'(a_rdy), 64'h1);
      chk("s_rdy_after_release", 64'(s_rdy), 64'h1);

      // Bit-serial CRC-16/CCITT-FALSE, 72 beats MSB first
      for (int k = 0; k < 72; k++) begin
         s_din[0] = sm[71-k];
         s_vld_i  = 1'b1;
         s_last   = (k == 71);
         @(posedge clk); #1;
      end
      s_vld_i = 1'b0; s_last = 1'b0;
      chk("s_vld",   64'(s_vld),   64'h1);
      chk("s_out",   64'(s_out),   64'h29B1);
      chk("s_ok",    64'(s_ok),    64'h0);
      chk("s_beats", 64'(s_beats), 64'd72);
      s_crc_rdy = 1'b1;
      @(posedge clk); #1;
      s_crc_rdy = 1'b0;
      chk("s_vld_drop", 64'(s_vld), 64'h0);
      chk("s_rdy_back", 64'(s_rdy), 64'h1);

      // Table of frames, run back to back
      for (int i = 0; i < 6; i++) begin
         wait_rdy();
         send_beats(vecs[i].msg, vecs[i].len, 1'b1);
         check_vec(vecs[i]);
         release_result();
      end

      // Handshake: din_last without din_vld ignored; result held while crc_rdy=0
      wait_rdy();
      send_beats(96'h31, 1, 1'b0);
      din_last = 1'b1;
      @(posedge clk); #1;
      din_last = 1'b0;
      chk("last_without_vld", 64'(a_vld), 64'h0);
      send_beats({32'h0, "23456789"}, 8, 1'b1);
      chk("hs_vld_rise", 64'(a_vld), 64'h1);
      din = 8'hAA; din_vld = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("hold_vld",   64'(a_vld),   64'h1);
         chk("hold_out",   64'(a_out),   64'hF4);
         chk("hold_rdy",   64'(a_rdy),   64'h0);
         chk("hold_beats", 64'(a_beats), 64'd9);
      end
      din_vld = 1'b0; din = 8'h00;
      release_result();

      // Abort mid-frame with a beat presented alongside clr
      wait_rdy();
      send_beats({64'h0, "1234"}, 4, 1'b0);
      din = 8'h35; din_vld = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; din_vld = 1'b0; din = 8'h00;
      chk("clr_vld",  64'(a_vld), 64'h0);
      chk("clr_rdy",  64'(a_rdy), 64'h1);
      @(posedge clk); #1;
      chk("clr_no_result", 64'(a_vld), 64'h0);
      send_beats(vecs[0].msg, 9, 1'b1);
      check_vec(vecs[0]);
      release_result();

      // Reset while a result is pending
      wait_rdy();
      send_beats(vecs[0].msg, 9, 1'b1);
      chk("pre_rst_vld", 64'(a_vld), 64'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("out_rst_vld",   64'(a_vld),   64'h0);
      chk("out_rst_out",   64'(a_out),   64'h0);
      chk("out_rst_ok",    64'(a_ok),    64'h0);
      chk("out_rst_beats", 64'(a_beats), 64'h0);
      chk("out_rst_rdy",   64'(a_rdy),   64'h0);
      @(posedge clk); #1;
      chk("out_rst_rdy_rise", 64'(a_rdy), 64'h1);
      send_beats(vecs[0].msg, 9, 1'b1);
      check_vec(vecs[0]);
      release_result();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/crc_engine.md
Name: crc_engine

Overview:
- Parametrised CRC generator/checker and the next generation of the serial CRC8 block.
- Configurable CRC width, polynomial, init, xorout, input/output reflection, and input beat width; DATA_W=1 gives the bit-serial case.
- Frames are delimited by an explicit last flag.
- The result is held under a valid/ready handshake with a residue-check flag, so one engine serves both TX append and RX check paths.

Parameters:
- CRC_W, 8: CRC width in bits, 1..32.
- POLY, 8'h07: generator polynomial, implicit x^CRC_W term omitted.
- INIT, 8'h00: register value loaded at frame start.
- XOROUT, 8'h00: XOR mask applied to the result.
- REFIN, 0: 1 = each beat is consumed LSB first; 0 = MSB first.
- REFOUT, 0: 1 = result bit-reversed before XOROUT.
- DATA_W, 8: bits consumed per accepted beat, 1..64.
- RESIDUE, 8'h00: expected raw register value after data plus appended CRC; used for crc_ok.
- CNT_W, 16: beat counter width.

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous frame abort
- din  in  DATA_W  input beat
- din_vld  in  1  beat valid
- din_last  in  1  beat is the last of the frame; qualified by din_vld
- din_rdy  out  1  engine accepts a beat
- crc_out  out  CRC_W  final CRC: reflect (if REFOUT), then XOR XOROUT
- crc_ok  out  1  raw register == RESIDUE at frame end
- crc_beats  out  CNT_W  beats accepted in the frame
- crc_vld  out  1  result valid
- crc_rdy  in  1  downstream accepts the result

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, crc_reg=INIT, beat counter=0, din_rdy=0, crc_vld=0, crc_out=0, crc_ok=0, crc_beats=0.
  - din_rdy rises the cycle after rst deasserts.
- Beat acceptance: a beat is accepted when din_vld && din_rdy.
- Per-bit step, direct (non-augmented) algorithm, no zero padding:
  - fb = crc_reg[CRC_W-1] ^ d
  - crc_reg = {crc_reg[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
- Bit order within a beat: DATA_W bits are processed in one cycle as an unrolled combinational chain. Order is din[DATA_W-1] down to din[0] when REFIN=0, and din[0] up when REFIN=1.
- FSM:
  - IDLE: din_rdy=1. An accepted beat updates crc_reg starting from INIT and sets the count to 1.
    - With din_last: go to OUTPUT.
    - Otherwise: go to BUSY.
  - BUSY: din_rdy=1. An accepted beat updates crc_reg from its current value and increments the count (saturates at all-ones).
    - With din_last: go to OUTPUT.
    - No beat: hold state.
  - OUTPUT: din_rdy=0. crc_vld=1; crc_out, crc_ok and crc_beats are registered and stable.
    - crc_rdy=1: go to IDLE next cycle, crc_vld drops.
    - Otherwise: hold all outputs.
- Latency: crc_vld rises on the cycle after the last beat is accepted.
  - Minimum frame period: 1 beat + 1 output cycle, i.e. one dead cycle between frames.
- Idle outputs: crc_out, crc_ok and crc_beats are 0 whenever crc_vld=0.
- crc_ok compares the raw crc_reg, before reflection and XOROUT, against RESIDUE.
- clr: any state goes to IDLE next cycle; crc_reg=INIT, count=0, crc_vld=0.
  - A beat presented in the same cycle is dropped.
  - A pending result is discarded.
  - rst has priority over clr.
- din_last with din_vld=0 is ignored.
- din_vld while in OUTPUT is not accepted (din_rdy=0); the source must hold.
- Single-beat frame (din_last on the first beat) is legal.
- Width rules:
  - POLY, INIT, XOROUT and RESIDUE are taken as CRC_W bits.
  - crc_beats wraps never; it saturates.

Test Plan:
- CRC-8 defaults: bytes "123456789" (0x31..0x39), din_last on 0x39 → crc_vld one cycle later; crc_out=0xF4, crc_beats=9. Single byte 0x01 → 0x07.
- Residue check: CRC-8 "123456789" followed by 0xF4 as 10th beat → crc_ok=1, crc_beats=10. Corrupt one data bit → crc_ok=0.
- CRC-16/CCITT-FALSE (CRC_W=16, POLY=0x1021, INIT=0xFFFF) on "123456789" → 0x29B1. Same with DATA_W=1, 72 serial beats MSB first → 0x29B1, crc_beats=72.
- CRC-32 (POLY=0x04C11DB7, INIT=XOROUT=0xFFFFFFFF, REFIN=REFOUT=1, DATA_W=32), beats 0x34333231, 0x38373635 then DATA_W... (use DATA_W=8 variant) "123456789" → 0xCBF43926.
- Handshake: hold crc_rdy=0 for 5 cycles → crc_vld, crc_out and din_rdy=0 stable. Release → IDLE next cycle. Back-to-back frames give identical results with no INIT carry-over.
- Abort/reset: clr mid-frame after 4 bytes, together with a valid beat → beat dropped, no crc_vld. A fresh "123456789" then yields 0xF4. rst during OUTPUT → crc_vld=0 next cycle, all outputs at reset values.
